// File: rtl/dff_pkg.sv
// dff_pkg: shared constants and elaboration helpers for the dff_reg register bank.
//   DFF_DEFAULT_WIDTH / DFF_DEFAULT_STAGES : default parameter values
//   DFF_MAX_WIDTH / DFF_MAX_STAGES         : upper ends of the legal parameter ranges
//   dff_zero_value()                       : all-zeros word, truncated by the caller to its WIDTH
//   dff_width_ok() / dff_stages_ok()       : parameter range checks used at elaboration
package dff_pkg;

    localparam int unsigned DFF_DEFAULT_WIDTH  = 1;
    localparam int unsigned DFF_DEFAULT_STAGES = 1;
    localparam int unsigned DFF_MAX_WIDTH      = 1024;
    localparam int unsigned DFF_MAX_STAGES     = 64;

    typedef logic [DFF_MAX_WIDTH-1:0] dff_word_t;

    // Widest possible zero word; any WIDTH takes its low bits with an explicit cast.
    function automatic dff_word_t dff_zero_value();
        return '0;
    endfunction

    function automatic bit dff_width_ok(input int width);
        return (width >= 1) && (width <= int'(DFF_MAX_WIDTH));
    endfunction

    function automatic bit dff_stages_ok(input int stages);
        return (stages >= 1) && (stages <= int'(DFF_MAX_STAGES));
    endfunction

endpackage

// File: rtl/dff_stage.sv
// dff_stage: one WIDTH-bit D flop with asynchronous active-high reset to RESET_VALUE.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces q to RESET_VALUE immediately
//   d     : data captured on every rising edge outside reset
//   q     : registered data
module dff_stage
    import dff_pkg::*;
#(
    parameter int              WIDTH       = int'(DFF_DEFAULT_WIDTH),
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(dff_zero_value())
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset is in the sensitivity list, so it wins over a coincident clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_reg.sv
// dff_reg: parameterised D register bank, optionally a STAGES-deep delay line.
//   clk   : rising-edge clock; every edge outside reset captures (no enable)
//   reset : asynchronous, active-high; every stage loads RESET_VALUE at once
//   d     : WIDTH-bit data into stage 0
//   q     : WIDTH-bit data from the last stage flop, STAGES edges after d
module dff_reg
    import dff_pkg::*;
#(
    parameter int               WIDTH       = int'(DFF_DEFAULT_WIDTH),
    parameter int               STAGES      = int'(DFF_DEFAULT_STAGES),
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(dff_zero_value())
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Illegal geometry stops elaboration rather than building a degenerate bank.
    if (!dff_width_ok(WIDTH)) begin : g_bad_width
        $fatal(1, "dff_reg: WIDTH=%0d outside 1..%0d", WIDTH, DFF_MAX_WIDTH);
    end
    if (!dff_stages_ok(STAGES)) begin : g_bad_stages
        $fatal(1, "dff_reg: STAGES=%0d outside 1..%0d", STAGES, DFF_MAX_STAGES);
    end

    // chain[0] is the input word; chain[k+1] is the output of stage k.
    logic [STAGES:0][WIDTH-1:0] chain;

    assign chain[0] = d;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        dff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .d     (chain[i]),
            .q     (chain[i+1])
        );
    end

    // Output comes straight from the last flop; no combinational path from d.
    assign q = chain[STAGES];

endmodule

// File: tb/tb_dff_reg.sv
// tb_dff_reg: scoreboard bench for dff_reg across five parameter sets.
// Reference model: q is the word captured STAGES edges ago, or RESET_VALUE when
// fewer than STAGES capturing edges have happened since reset was last high.
module tb_dff_reg;

    localparam int NDUT = 5;
    localparam int LOGN = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        d0, q0;
    logic [7:0]  d1, q1;
    logic [3:0]  d2, q2;
    logic [63:0] d3, q3;
    logic [15:0] d4, q4;

    dff_reg u_dut0 (.clk(clk), .reset(reset), .d(d0), .q(q0));

    dff_reg #(.WIDTH(8), .STAGES(1), .RESET_VALUE(8'hA5))
        u_dut1 (.clk(clk), .reset(reset), .d(d1), .q(q1));

    dff_reg #(.WIDTH(4), .STAGES(3), .RESET_VALUE(4'h6))
        u_dut2 (.clk(clk), .reset(reset), .d(d2), .q(q2));

    dff_reg #(.WIDTH(64), .STAGES(1))
        u_dut3 (.clk(clk), .reset(reset), .d(d3), .q(q3));

    dff_reg #(.WIDTH(16), .STAGES(5), .RESET_VALUE(16'hC3E1))
        u_dut4 (.clk(clk), .reset(reset), .d(d4), .q(q4));

    int          stg [NDUT] = '{1, 1, 3, 1, 5};
    logic [63:0] rv  [NDUT] = '{64'h0, 64'hA5, 64'h6, 64'h0, 64'hC3E1};

    logic [63:0] dlog [NDUT][LOGN];
    int          cap = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          id;
        logic [63:0] exp;
    } sb_t;
    sb_t sbq[$];

    function automatic logic [63:0] model_q(input int k);
        if (cap >= stg[k]) return dlog[k][cap - stg[k]];
        return rv[k];
    endfunction

    function automatic logic [63:0] dut_q(input int k);
        case (k)
            0:       return 64'(q0);
            1:       return 64'(q1);
            2:       return 64'(q2);
            3:       return q3;
            default: return 64'(q4);
        endcase
    endfunction

    task automatic push_all();
        for (int k = 0; k < NDUT; k++) begin
            sb_t e;
            e.id  = k;
            e.exp = model_q(k);
            sbq.push_back(e);
        end
    endtask

    // Model update on every rising edge, then queue the expected outputs.
    always @(posedge clk) begin
        if (reset) begin
            cap = 0;
        end else if (cap < LOGN) begin
            dlog[0][cap] = 64'(d0);
            dlog[1][cap] = 64'(d1);
            dlog[2][cap] = 64'(d2);
            dlog[3][cap] = d3;
            dlog[4][cap] = 64'(d4);
            cap++;
        end
        push_all();
    end

    // Monitor: shortly after each clock transition, drain and compare the queue.
    initial begin
        forever begin
            @(clk);
            #1;
            while (sbq.size() > 0) begin
                sb_t         e;
                logic [63:0] act;
                e   = sbq.pop_front();
                act = dut_q(e.id);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL q_dut%0d at %0t: got %h want %h", e.id, $time, act, e.exp);
                end
            end
        end
    end

    // Watchdog: the stimulus must finish well before this wait expires.
    initial begin
        #100000;
        $display("FAIL timeout at %0t: stimulus did not complete", $time);
        $display("TEST FAILED");
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_d();
        d0 = 1'($urandom);
        d1 = 8'($urandom);
        d2 = 4'($urandom);
        d3 = {32'($urandom), 32'($urandom)};
        d4 = 16'($urandom);
    endtask

    // Assert reset between edges; the monitor checks RESET_VALUE before the next edge.
    task automatic async_reset(input int hold);
        reset = 1'b1;
        cap   = 0;
        push_all();
        repeat (hold) begin
            tick();
            rand_d();
        end
        reset = 1'b0;
    endtask

    logic [11:0] d0_seq;
    logic [63:0] base;

    initial begin
        reset  = 1'b1;
        d0     = 1'b0;
        d1     = 8'h00;
        d2     = 4'h0;
        d3     = 64'h0;
        d4     = 16'h0;
        d0_seq = 12'b0111_1110_0111;
        base   = 64'hDEAD_BEEF_0123_4567;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (dut_q(k) !== rv[k]) begin
                bad++;
                $display("FAIL reset state q_dut%0d at %0t: got %h want %h",
                         k, $time, dut_q(k), rv[k]);
            end
        end
        push_all();
        repeat (3) tick();
        reset = 1'b0;

        // Basic capture, falling data, delay-line counter, wide word.
        for (int c = 0; c < 12; c++) begin
            tick();
            d0 = d0_seq[c];
            d1 = 8'h3C;
            d2 = 4'(c + 1);
            d3 = base;
            d4 = 16'($urandom);
        end

        // Mid-stream async reset, held over 3 edges with d1 = FF, then release with 5A.
        reset = 1'b1;
        cap   = 0;
        #1;
        total++;
        if ((q1 !== 8'hA5) || (q2 !== 4'h6)) begin
            bad++;
            $display("FAIL async reset at %0t: q1=%h q2=%h want A5/6", $time, q1, q2);
        end
        push_all();
        d1 = 8'hFF;
        repeat (3) begin
            tick();
            d2 = d2 + 4'd1;
        end
        reset = 1'b0;
        d1    = 8'h5A;
        for (int c = 0; c < 8; c++) begin
            tick();
            d2 = d2 + 4'd1;
            d4 = 16'($urandom);
        end

        // Walking single-bit flips on the wide word.
        for (int i = 0; i < 64; i++) begin
            tick();
            d3 = base ^ (64'd1 << i);
            d0 = 1'(i);
        end

        // Randomised traffic with occasional async resets.
        for (int c = 0; c < 200; c++) begin
            tick();
            rand_d();
            if ($urandom_range(0, 39) == 0) begin
                async_reset(int'($urandom_range(1, 3)));
            end
        end

        tick();
        tick();
        #10;
        $display("test done: total=%0d bad=%0d", total, bad);
        if (bad == 0) $display("TEST PASSED");
        else          $display("TEST FAILED");
        $finish;
    end

endmodule
